// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between a requester and the ALU sequencer.
// The sequencer connects through the slave modport, the requester through master.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_z;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: takes one operation at a time, drives the shared ALU for one cycle and
// holds the result until consumed. Define ALU_SEQUENCER_DIV_EN to include the restoring divider.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | shared ALU driven for one cycle, result captured
// DIV   | restoring divide, one quotient bit per cycle (ALU_SEQUENCER_DIV_EN only)
// DONE  | response presented until rsp_ready
module alu_sequencer (
  input  logic           clk,
  input  logic           resetn,
  alu_sequencer_if.slave bus,
  output logic [31:0]    alu_x,
  output logic [31:0]    alu_y,
  output logic [15:0]    alu_opp,
  input  logic [63:0]    alu_z
);
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_INC = 4'd13;

`ifdef ALU_SEQUENCER_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic        ill_q, ill_d;
  logic [63:0] z_q, z_d;
  logic        err_q, err_d;
  logic        req_legal;

`ifdef ALU_SEQUENCER_DIV_EN
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        trial_ge;

  // Quotient register starts as the dividend and shifts its MSB into the partial remainder.
  assign trial    = {rem_q, quo_q[31]};
  assign diff     = trial - {1'b0, y_q};
  assign trial_ge = ~diff[32];
`endif

  always_comb begin
    req_legal = (bus.req_op <= OP_INC);
`ifndef ALU_SEQUENCER_DIV_EN
    if (bus.req_op == OP_DIV) req_legal = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ill_q   <= 1'b0;
      z_q     <= '0;
      err_q   <= 1'b0;
`ifdef ALU_SEQUENCER_DIV_EN
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ill_q   <= ill_d;
      z_q     <= z_d;
      err_q   <= err_d;
`ifdef ALU_SEQUENCER_DIV_EN
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    ill_d   = ill_q;
    z_d     = z_q;
    err_d   = err_q;
`ifdef ALU_SEQUENCER_DIV_EN
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          x_d     = bus.req_x;
          y_d     = bus.req_y;
          ill_d   = ~req_legal;
          // Illegal ops also pass through EXEC (ALU idle) so every non-divide answer lands in N+2.
          state_d = EXEC;
`ifdef ALU_SEQUENCER_DIV_EN
          if (bus.req_op == OP_DIV) begin
            cnt_d   = 5'd31;
            rem_d   = '0;
            quo_d   = bus.req_x;
            state_d = DIV;
          end
`endif
        end
      end
      EXEC: begin
        z_d     = ill_q ? 64'd0 : alu_z;
        err_d   = ill_q;
        state_d = DONE;
      end
`ifdef ALU_SEQUENCER_DIV_EN
      DIV: begin
        if (y_q == 32'd0) begin
          z_d     = {x_q, 32'hFFFF_FFFF};
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          rem_d = trial_ge ? diff[31:0] : trial[31:0];
          quo_d = {quo_q[30:0], trial_ge};
          if (cnt_q == 5'd0) begin
            z_d     = {rem_d, quo_d};
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
`endif
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_z     = z_q;
  assign bus.rsp_err   = err_q;
  assign alu_x         = x_q;
  assign alu_y         = y_q;
  assign alu_opp       = (state_q == EXEC && !ill_q) ? (16'h0001 << op_q) : 16'h0000;

endmodule
